// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type, default
// operand width, and a helper that sizes the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // The counter only has to reach width-1, so clog2(width) bits are enough
  // for any width >= 2.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder cell.
// Ports:
//   x, y  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out (majority of x, y, cin)
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial adder: captures two operands on an accepted Start pulse, adds
// them LSB first through one full-adder cell (one bit per clock), then
// publishes a registered Sum with unsigned carry-out and signed overflow.
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - synchronous active-high reset
//   Start    - one-cycle start pulse, honoured only in IDLE
//   A_In     - operand A, sampled on accepted Start
//   B_In     - operand B, sampled on accepted Start
//   Sum      - result, held until the next completion
//   Cout     - carry out of the MSB for the last completed add
//   Overflow - two's complement overflow for the last completed add
//   Busy     - high while bits are being shifted through the adder
//   Done     - one-cycle pulse when Sum/Cout/Overflow update
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start; outputs hold the last completed result
// SHIFT | one operand bit pair added per cycle, WIDTH cycles in total
// DONE  | Done pulse cycle; always returns to IDLE
module serial_adder16
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    count;

  logic             fa_s;
  logic             fa_c;

  full_adder u_full_adder (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          Busy <= 1'b0;
          if (Start) begin
            a_sr  <= A_In;
            b_sr  <= B_In;
            psum  <= '0;
            carry <= 1'b0;
            count <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= {fa_s, psum[WIDTH-1:1]};
          carry <= fa_c;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            // Carry into the MSB differing from carry out of it is exactly
            // the two's complement overflow condition.
            Sum      <= {fa_s, psum[WIDTH-1:1]};
            Cout     <= fa_c;
            Overflow <= carry ^ fa_c;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: directed corner cases, ignored
// Start pulses, mid-operation reset and randomised operand pairs compared
// against an integer-arithmetic reference model.
module tb_serial_adder16;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] A_In;
  logic [15:0] B_In;
  logic [15:0] Sum;
  logic        Cout;
  logic        Overflow;
  logic        Busy;
  logic        Done;

  int total  = 0;
  int passed = 0;

  // Result the outputs should currently be holding.
  logic [15:0] held_sum;
  logic        held_cout;
  logic        held_ovf;

  serial_adder16 #(.WIDTH(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A_In     (A_In),
    .B_In     (B_In),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer addition, unsigned for carry, signed for overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, us, ss;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    us = ua + ub;
    ss = sa + sb;
    s  = 16'(us % 65536);
    c  = (us >= 65536);
    v  = (ss > 32767) || (ss < -32768);
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] es;
    logic        ec, ev;
    int          busy_cnt;
    int          lat;
    bit          held_ok;
    model(a, b, es, ec, ev);
    Start = 1'b1;
    A_In  = a;
    B_In  = b;
    step();
    Start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    held_ok  = 1'b1;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) busy_cnt++;
      if (Sum !== held_sum || Cout !== held_cout || Overflow !== held_ovf) held_ok = 1'b0;
      A_In = 16'($urandom);
      B_In = 16'($urandom);
      step();
      lat++;
    end
    check({tag, "_done_seen"}, 32'(Done), 32'(1));
    check({tag, "_latency"}, 32'(lat), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, "_held"}, 32'(held_ok), 32'(1));
    check({tag, "_sum"}, 32'(Sum), 32'(es));
    check({tag, "_cout"}, 32'(Cout), 32'(ec));
    check({tag, "_ovf"}, 32'(Overflow), 32'(ev));
    held_sum  = es;
    held_cout = ec;
    held_ovf  = ev;
    step();
    check({tag, "_done_width"}, 32'(Done), 32'(0));
    check({tag, "_busy_after"}, 32'(Busy), 32'(0));
  endtask

  initial begin
    int done_cnt;
    Reset = 1'b1;
    Start = 1'b0;
    A_In  = 16'h0;
    B_In  = 16'h0;
    held_sum  = 16'h0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;
    step();
    step();
    Reset = 1'b0;
    check("rst_sum", 32'(Sum), 32'h0);
    check("rst_cout", 32'(Cout), 32'h0);
    check("rst_ovf", 32'(Overflow), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    step();

    run_add("one_plus_one", 16'h0001, 16'h0001);
    run_add("ffff_plus_1", 16'hFFFF, 16'h0001);
    run_add("8000_plus_8000", 16'h8000, 16'h8000);
    run_add("7fff_plus_1", 16'h7FFF, 16'h0001);
    run_add("zero_plus_zero", 16'h0000, 16'h0000);
    run_add("ffff_plus_ffff", 16'hFFFF, 16'hFFFF);

    // Start pulses during SHIFT (edges 5 and 16) and DONE (edge 17) are ignored.
    Start = 1'b1;
    A_In  = 16'h1234;
    B_In  = 16'h4321;
    step();
    Start    = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      if (Done === 1'b1) begin
        done_cnt++;
        check("ign_sum", 32'(Sum), 32'h5555);
        check("ign_latency", 32'(k), 32'd17);
      end
      Start = (k == 5 || k == 16 || k == 17);
      A_In  = 16'hFFFF;
      B_In  = 16'hFFFF;
      step();
    end
    Start = 1'b0;
    check("ign_done_count", 32'(done_cnt), 32'd1);
    check("ign_busy_idle", 32'(Busy), 32'h0);
    held_sum  = 16'h5555;
    held_cout = 1'b0;
    held_ovf  = 1'b0;

    // Reset mid-operation aborts the add without a Done pulse.
    Start = 1'b1;
    A_In  = 16'h00FF;
    B_In  = 16'h0F0F;
    step();
    Start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rstmid_busy", 32'(Busy), 32'h0);
    check("rstmid_sum", 32'(Sum), 32'h0);
    check("rstmid_cout", 32'(Cout), 32'h0);
    check("rstmid_ovf", 32'(Overflow), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done === 1'b1 || Busy === 1'b1) done_cnt++;
      step();
    end
    check("rstmid_no_done", 32'(done_cnt), 32'd0);
    held_sum  = 16'h0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;

    run_add("after_reset", 16'h00FF, 16'h0F0F);

    for (int i = 0; i < 500; i++) begin
      run_add("rand", 16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
